mem_preload: RTL and testbench
==============================

# mem_preload

Parametrised preload/verify engine between a source image port and the `memunit` SDRAM front-end. On `start` it streams `length` words from a synchronous source port into memory at `base_addr`, issuing one write per word through the memunit handshake. It optionally reads every word back and compares it against the source. It replaces bench-side backdoor preloading with a synthesizable path usable at boot and in self-test.

## Interface
Parameters:
- `ADDR_W`, 16: memory and source address width; also the width of `length` and `err_count`.
- `DATA_W`, 16: word width.
- `TIMEOUT`, 1024: maximum cycles spent waiting in any single memunit handshake phase before abort; 0 disables the watchdog.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  launch a job; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first memory address; latched at start.
- `length`  in  ADDR_W  word count; latched at start. 0 = empty job.
- `verify_en`  in  1  run the readback pass; latched at start.
- `src_addr`  out  ADDR_W  source word offset (0..length-1).
- `src_data`  in  DATA_W  source word; valid exactly 1 cycle after `src_addr` changes.
- `mem_ready`  in  1  memunit ready.
- `mem_enable`  out  1  memunit request.
- `mem_rwn`  out  1  1 = read, 0 = write.
- `mem_addr`  out  ADDR_W  memunit address.
- `mem_wdata`  out  DATA_W  memunit write data.
- `mem_rdata`  in  DATA_W  memunit read data.
- `mem_valid`  in  1  memunit read-data strobe.
- `busy`  out  1  job in progress.
- `done`  out  1  1-cycle pulse at job end, including empty and aborted jobs.
- `error`  out  1  sticky; cleared by the next accepted start.
- `timeout`  out  1  sticky; the job was aborted by the watchdog. Cleared by the next accepted start.
- `err_addr`  out  ADDR_W  memory address of the first verify mismatch.
- `err_count`  out  ADDR_W  number of mismatches, saturating at all-ones.

## Operation
- States: IDLE, FETCH, ISSUE, WAIT, then VFETCH, RISSUE, RWAIT, then FIN.
- IDLE:
  - On `start`: latch `base_addr`, `length`, `verify_en`; clear `error`, `timeout`, `err_addr`, `err_count`; index i=0.
  - If `length`==0, go to FIN. Otherwise go to FETCH.
  - `start` in any other state is ignored.
- FETCH: drive `src_addr`=i; wait 1 cycle; capture `src_data`.
- ISSUE:
  - Drive `mem_enable`=1, `mem_rwn`=0, `mem_addr`=(base+i) mod 2^ADDR_W, `mem_wdata`=captured word.
  - The request is accepted on the first cycle in which `mem_ready`=0 while `mem_enable`=1. `mem_enable` deasserts on the next cycle; go to WAIT.
- WAIT: hold `mem_addr`/`mem_wdata`; wait for `mem_ready`=1. Then i++.
  - If i==length and `verify_en`=1: set i=0 and go to VFETCH.
  - If i==length and `verify_en`=0: go to FIN.
  - Otherwise go to FETCH.
- VFETCH/RISSUE: same as FETCH/ISSUE but with `mem_rwn`=1.
- RWAIT:
  - Capture `mem_rdata` on the first `mem_valid` cycle and compare it to the source word.
  - When `mem_ready`=1, the word is a mismatch if the data differs or no `mem_valid` was seen.
  - On a mismatch: set `error`; increment `err_count` (saturating); record `err_addr` if this is the first mismatch.
  - Advance i as in WAIT; go to FIN after the last word.
- FIN: pulse `done`; go to IDLE.
- Watchdog:
  - Counts cycles spent in ISSUE/WAIT/RISSUE/RWAIT; resets on every state change.
  - On reaching TIMEOUT: set `error` and `timeout`, drop `mem_enable`, go to FIN.
- Address arithmetic wraps modulo 2^ADDR_W. `src_addr` never wraps because i < length.

## Timing
- Reset values:
  - `busy`, `done`, `error`, `timeout`, `mem_enable` = 0.
  - `mem_rwn` = 1.
  - `mem_addr`, `mem_wdata`, `src_addr`, `err_addr`, `err_count` = 0.
  - State = IDLE.
- Reset mid-job: all of the above values apply on the next edge. The in-flight memunit access is abandoned; no completion is awaited.
- `busy` rises the cycle after start is accepted and falls together with the `done` pulse.
- All outputs are registered.
- Per-word write cost = 1 (FETCH) + acceptance latency + completion latency. The same cost applies per word for readback.
- Empty job: `done` pulses 2 cycles after `start`; `busy` is high for 1 cycle.
- `mem_valid` outside RWAIT is ignored.
- A second `mem_valid` within one RWAIT is ignored.

## Test plan
- Reset, then start with base=0x0000, length=4, verify_en=0, and source words 0x000B, 0x1234, 0xBEEF, 0xFFFF -> exactly 4 writes to 0..3 with matching data; `done` pulses once; `error`=0.
- The same job with verify_en=1 and an SDRAM model -> 4 writes followed by 4 reads; `error`=0 and `err_count`=0.
- verify_en=1 with the model word at address 2 corrupted after the write pass -> `error`=1, `err_addr`=0x0002, `err_count`=1.
- base=0xFFFE, length=4 -> write addresses are 0xFFFE, 0xFFFF, 0x0000, 0x0001 and `src_addr` runs 0..3.
- `mem_ready` held low forever with TIMEOUT=16 -> abort; `timeout`=1, `error`=1, `done` pulses and `mem_enable`=0. A second start is accepted afterwards and clears both flags.
- length=0 -> `done` 2 cycles after `start` and no `mem_enable`. Separately: assert `rst` during WAIT -> every output at its reset value on the next edge.

Source files
------------

// File: rtl/mem_preload.sv
`default_nettype none
// ============================================================================
// Module   : mem_preload
// Brief    : Streams a source image into memunit, with optional readback verify.
// Revision : 1.0 - initial release
// ============================================================================
module mem_preload #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic              verify_en,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    input  logic              mem_ready,
    output logic              mem_enable,
    output logic              mem_rwn,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              timeout,
    output logic [ADDR_W-1:0] err_addr,
    output logic [ADDR_W-1:0] err_count
);

    // Watchdog counter only needs to hold 0..TIMEOUT-1.
    localparam int c_WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_VFETCH = 3'd4,
        S_RISSUE = 3'd5,
        S_RWAIT  = 3'd6,
        S_FIN    = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_len;
    logic [ADDR_W-1:0]   r_idx;
    logic                r_verify;
    logic [c_WD_W-1:0]   r_wd;
    logic                r_seen;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_in_wait;
    logic                w_expire;
    logic                w_abort;
    logic [ADDR_W-1:0]   w_idx_inc;
    logic                w_last;
    logic [ADDR_W-1:0]   w_idx_next;
    logic                w_rd_seen;
    logic [DATA_W-1:0]   w_rd_word;
    logic                w_mismatch;

    assign w_in_wait  = (r_state == S_ISSUE) || (r_state == S_WAIT) ||
                        (r_state == S_RISSUE) || (r_state == S_RWAIT);
    assign w_expire   = (TIMEOUT != 0) && w_in_wait && (r_wd == c_WD_LAST);
    assign w_idx_inc  = r_idx + ADDR_W'(1);
    assign w_last     = (w_idx_inc == r_len);
    assign w_idx_next = w_last ? '0 : w_idx_inc;
    // Read data may arrive in the same cycle that ready rises.
    assign w_rd_seen  = r_seen | mem_valid;
    assign w_rd_word  = r_seen ? r_rdata : mem_rdata;
    assign w_mismatch = !w_rd_seen || (w_rd_word != mem_wdata);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE:   if (start) w_state_next = (length == '0) ? S_FIN : S_FETCH;
            S_FETCH:  w_state_next = S_ISSUE;
            S_VFETCH: w_state_next = S_RISSUE;
            S_ISSUE: begin
                if (!mem_ready) begin
                    w_state_next = S_WAIT;
                end else if (w_expire) begin
                    w_abort      = 1'b1;
                    w_state_next = S_FIN;
                end
            end
            S_RISSUE: begin
                if (!mem_ready) begin
                    w_state_next = S_RWAIT;
                end else if (w_expire) begin
                    w_abort      = 1'b1;
                    w_state_next = S_FIN;
                end
            end
            S_WAIT: begin
                if (mem_ready) begin
                    if (!w_last)       w_state_next = S_FETCH;
                    else if (r_verify) w_state_next = S_VFETCH;
                    else               w_state_next = S_FIN;
                end else if (w_expire) begin
                    w_abort      = 1'b1;
                    w_state_next = S_FIN;
                end
            end
            S_RWAIT: begin
                if (mem_ready) begin
                    w_state_next = w_last ? S_FIN : S_VFETCH;
                end else if (w_expire) begin
                    w_abort      = 1'b1;
                    w_state_next = S_FIN;
                end
            end
            S_FIN:    w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            timeout    <= 1'b0;
            mem_enable <= 1'b0;
            mem_rwn    <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            src_addr   <= '0;
            err_addr   <= '0;
            err_count  <= '0;
            r_base     <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_verify   <= 1'b0;
            r_wd       <= '0;
            r_seen     <= 1'b0;
            r_rdata    <= '0;
        end else begin
            done <= 1'b0;
            if (w_state_next != r_state) begin
                r_wd <= '0;
            end else if (w_in_wait && (TIMEOUT != 0)) begin
                r_wd <= r_wd + c_WD_W'(1);
            end
            if (w_abort) begin
                error      <= 1'b1;
                timeout    <= 1'b1;
                mem_enable <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base    <= base_addr;
                        r_len     <= length;
                        r_verify  <= verify_en;
                        r_idx     <= '0;
                        src_addr  <= '0;
                        error     <= 1'b0;
                        timeout   <= 1'b0;
                        err_addr  <= '0;
                        err_count <= '0;
                        busy      <= 1'b1;
                    end
                end
                S_FETCH, S_VFETCH: begin
                    mem_enable <= 1'b1;
                    mem_rwn    <= (r_state == S_VFETCH);
                    mem_addr   <= r_base + r_idx;
                    mem_wdata  <= src_data;
                    r_seen     <= 1'b0;
                end
                S_ISSUE, S_RISSUE: begin
                    if (!mem_ready) mem_enable <= 1'b0;
                end
                S_WAIT: begin
                    if (mem_ready) begin
                        r_idx    <= w_idx_next;
                        src_addr <= w_idx_next;
                    end
                end
                S_RWAIT: begin
                    if (mem_valid && !r_seen) begin
                        r_seen  <= 1'b1;
                        r_rdata <= mem_rdata;
                    end
                    if (mem_ready) begin
                        r_idx    <= w_idx_next;
                        src_addr <= w_idx_next;
                        if (w_mismatch) begin
                            error <= 1'b1;
                            if (err_count != '1) err_count <= err_count + ADDR_W'(1);
                            if (err_count == '0) err_addr <= mem_addr;
                        end
                    end
                end
                S_FIN: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_preload.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_preload
// Brief    : Self-checking bench: job table, memunit model and transaction scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_preload;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] length;
    logic        verify_en;
    logic [15:0] src_addr;
    logic [15:0] src_data;
    logic        mem_ready;
    logic        mem_enable;
    logic        mem_rwn;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic        busy;
    logic        done;
    logic        error;
    logic        timeout;
    logic [15:0] err_addr;
    logic [15:0] err_count;

    mem_preload #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .length(length), .verify_en(verify_en), .src_addr(src_addr),
        .src_data(src_data), .mem_ready(mem_ready), .mem_enable(mem_enable),
        .mem_rwn(mem_rwn), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .busy(busy), .done(done),
        .error(error), .timeout(timeout), .err_addr(err_addr), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rwn;
        logic [15:0] addr;
        logic [15:0] idx;
        logic [15:0] data;
    } txn_t;

    typedef struct {
        logic [15:0] base;
        logic [15:0] len;
        logic        verify;
        logic        corrupt;
        logic [15:0] caddr;
        logic        exp_error;
        logic [15:0] exp_eaddr;
        logic [15:0] exp_ecount;
    } vec_t;

    txn_t        exp_q[$];
    vec_t        vecs[6];
    logic [15:0] src_img [0:7];
    logic [15:0] sdram [0:65535];

    int          n_checks = 0;
    int          n_err    = 0;
    int          m_cnt    = 0;
    logic        m_rd;
    logic [15:0] m_data;
    logic        hang, slow, corrupt_en, corrupted;
    logic [15:0] corrupt_addr;
    int          en_seen  = 0;

    assign src_data = src_img[src_addr[2:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memunit model: ready drops the cycle a request is seen, read data strobes one cycle before ready returns.
    task automatic model_step();
        txn_t e;
        if (rst) begin
            m_cnt     = 0;
            mem_ready = 1'b1;
            mem_valid = 1'b0;
            exp_q.delete();
        end else if (hang) begin
            mem_ready = 1'b0;
            mem_valid = 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                mem_ready = 1'b1;
                mem_valid = 1'b0;
            end else if (m_cnt == 1 && m_rd) begin
                mem_valid = 1'b1;
                mem_rdata = m_data;
            end else begin
                mem_valid = 1'b0;
            end
        end else if (mem_enable) begin
            if (exp_q.size() == 0) begin
                chk("txn_unexpected", {15'd0, mem_rwn, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("txn_rwn", mem_rwn, e.rwn);
                chk("txn_addr", mem_addr, e.addr);
                chk("txn_src_addr", src_addr, e.idx);
                if (!e.rwn) chk("txn_wdata", mem_wdata, e.data);
            end
            if (mem_rwn) begin
                if (corrupt_en && !corrupted) begin
                    sdram[corrupt_addr] = sdram[corrupt_addr] ^ 16'h00F0;
                    corrupted = 1'b1;
                end
                m_data = sdram[mem_addr];
            end else begin
                sdram[mem_addr] = mem_wdata;
            end
            m_rd      = mem_rwn;
            m_cnt     = slow ? 12 : 2 + int'(mem_addr % 16'd3);
            mem_ready = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_enable) en_seen++;
        model_step();
    endtask

    task automatic start_job(input logic [15:0] b, input logic [15:0] l, input logic v);
        base_addr = b;
        length    = l;
        verify_en = v;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        chk("error_cleared_at_start", error, 1'b0);
        chk("timeout_cleared_at_start", timeout, 1'b0);
    endtask

    task automatic wait_done(input int budget, output int ndone);
        int cyc = 0;
        ndone = 0;
        while (ndone == 0 && cyc < budget) begin
            tick();
            cyc++;
            if (done) ndone++;
        end
        repeat (3) begin
            tick();
            if (done) ndone++;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_error"}, error, 1'b0);
        chk({tag, "_timeout"}, timeout, 1'b0);
        chk({tag, "_mem_enable"}, mem_enable, 1'b0);
        chk({tag, "_mem_rwn"}, mem_rwn, 1'b1);
        chk({tag, "_mem_addr"}, mem_addr, 16'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 16'h0);
        chk({tag, "_src_addr"}, src_addr, 16'h0);
        chk({tag, "_err_addr"}, err_addr, 16'h0);
        chk({tag, "_err_count"}, err_count, 16'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        vec_t v;
        int   nd;
        int   c;
        int   en0;

        src_img[0] = 16'h000B; src_img[1] = 16'h1234;
        src_img[2] = 16'hBEEF; src_img[3] = 16'hFFFF;
        src_img[4] = 16'h5A5A; src_img[5] = 16'hA5A5;
        src_img[6] = 16'h0F0F; src_img[7] = 16'hF0F0;

        //           base      len    ver   cor   caddr     err   eaddr     ecount
        vecs[0] = '{16'h0000, 16'd4, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'd0};
        vecs[1] = '{16'h0000, 16'd4, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'd0};
        vecs[2] = '{16'h0000, 16'd4, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0002, 16'd1};
        vecs[3] = '{16'hFFFE, 16'd4, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'd0};
        vecs[4] = '{16'hFFFE, 16'd4, 1'b1, 1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 16'd1};
        vecs[5] = '{16'h1000, 16'd3, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'd0};

        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; verify_en = 1'b0;
        mem_ready = 1'b1; mem_valid = 1'b0; mem_rdata = '0;
        hang = 1'b0; slow = 1'b0; corrupt_en = 1'b0; corrupted = 1'b0; corrupt_addr = '0;
        m_rd = 1'b0; m_data = '0;

        repeat (3) tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();

        for (int k = 0; k < 6; k++) begin
            v            = vecs[k];
            corrupt_en   = v.corrupt;
            corrupt_addr = v.caddr;
            corrupted    = 1'b0;
            for (int i = 0; i < int'(v.len); i++)
                exp_q.push_back('{1'b0, v.base + 16'(i), 16'(i), src_img[i]});
            if (v.verify)
                for (int i = 0; i < int'(v.len); i++)
                    exp_q.push_back('{1'b1, v.base + 16'(i), 16'(i), src_img[i]});
            start_job(v.base, v.len, v.verify);
            wait_done(400, nd);
            chk($sformatf("job%0d_done_pulses", k), nd, 1);
            chk($sformatf("job%0d_error", k), error, v.exp_error);
            chk($sformatf("job%0d_timeout", k), timeout, 1'b0);
            chk($sformatf("job%0d_err_addr", k), err_addr, v.exp_eaddr);
            chk($sformatf("job%0d_err_count", k), err_count, v.exp_ecount);
            chk($sformatf("job%0d_txn_left", k), exp_q.size(), 0);
            chk($sformatf("job%0d_busy_end", k), busy, 1'b0);
        end
        corrupt_en = 1'b0;

        // Empty job: done two cycles after start, never a request.
        en0 = en_seen;
        start_job(16'h0055, 16'd0, 1'b1);
        chk("empty_done_early", done, 1'b0);
        tick();
        chk("empty_done", done, 1'b1);
        chk("empty_busy_fall", busy, 1'b0);
        tick();
        chk("empty_done_single", done, 1'b0);
        chk("empty_no_enable", en_seen - en0, 0);

        // Memunit never completes: watchdog abort, then a clean restart.
        hang = 1'b1;
        tick();
        start_job(16'h0000, 16'd4, 1'b0);
        wait_done(100, nd);
        chk("hang_done_pulses", nd, 1);
        chk("hang_timeout", timeout, 1'b1);
        chk("hang_error", error, 1'b1);
        chk("hang_mem_enable", mem_enable, 1'b0);
        chk("hang_busy", busy, 1'b0);
        hang = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) exp_q.push_back('{1'b0, 16'h0020 + 16'(i), 16'(i), src_img[i]});
        for (int i = 0; i < 2; i++) exp_q.push_back('{1'b1, 16'h0020 + 16'(i), 16'(i), src_img[i]});
        start_job(16'h0020, 16'd2, 1'b1);
        wait_done(200, nd);
        chk("restart_done_pulses", nd, 1);
        chk("restart_error", error, 1'b0);
        chk("restart_timeout", timeout, 1'b0);
        chk("restart_txn_left", exp_q.size(), 0);

        // Reset asserted while a write is outstanding.
        slow = 1'b1;
        exp_q.push_back('{1'b0, 16'h0100, 16'd0, src_img[0]});
        start_job(16'h0100, 16'd4, 1'b0);
        c = 0;
        while (mem_ready && c < 10) begin
            tick();
            c++;
        end
        chk("midjob_reached_accept", mem_ready, 1'b0);
        tick();
        chk("midjob_in_wait_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        chk_reset("midjob_reset");
        rst  = 1'b0;
        slow = 1'b0;
        tick();
        chk("post_reset_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
